// File: rtl/adsr_beat_pulse_filter.sv
// Radial pulse brightness filter for the heart-rate video path.
// A beat-retriggerable ADSR envelope scales a BPM-derived gain. The gain
// brightens pixels in a two-zone disc around a per-frame centre. Pixels move
// through a two-stage valid/ready pipeline with a global stall.
module adsr_beat_pulse_filter #(
    parameter int BITS         = 8,
    parameter int N_PIX        = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int MAX_BPM      = 200,
    parameter int TICK_DIV     = 200000,
    localparam int XW = $clog2(IMAGE_WIDTH),
    localparam int YW = $clog2(IMAGE_HEIGHT),
    localparam int BW = $clog2(MAX_BPM + 1),
    localparam int CW = $clog2(TICK_DIV)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PIX-1:0][BITS-1:0]  pix_in,
    input  logic [N_PIX-1:0][XW-1:0]    pixel_x,
    input  logic [YW-1:0]               pixel_y,
    input  logic                        sof,
    input  logic                        valid_in,
    output logic                        in_ready,
    output logic [N_PIX-1:0][BITS-1:0]  pix_out,
    output logic                        valid_out,
    input  logic                        out_ready,
    input  logic [XW-1:0]               cx_in,
    input  logic [YW-1:0]               cy_in,
    input  logic                        filter_enable,
    input  logic                        filter_mode,
    input  logic                        beat_trigger,
    input  logic [BW-1:0]               bpm_estimate,
    input  logic [7:0]                  pulse_amplitude,
    input  logic [7:0]                  attack_rate,
    input  logic [7:0]                  decay_rate,
    input  logic [7:0]                  release_rate,
    input  logic [7:0]                  sustain_level,
    input  logic [7:0]                  sustain_ticks,
    output logic [7:0]                  env_level,
    output logic [2:0]                  env_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } adsr_state_t;

    localparam int BPM_K = (256 * 256) / MAX_BPM;

    // ---------------- envelope tick ----------------
    logic [CW-1:0] tick_cnt_reg;
    logic          tick;
    assign tick = (tick_cnt_reg == CW'(TICK_DIV - 1));

    // Free-running divider; tick pulses on the wrap cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    tick_cnt_reg <= '0;
        else if (tick) tick_cnt_reg <= '0;
        else           tick_cnt_reg <= tick_cnt_reg + CW'(1);
    end

    // ---------------- ADSR envelope ----------------
    adsr_state_t state_reg, state_next;
    logic [7:0]  env_reg, env_next;
    logic [8:0]  sus_cnt_reg, sus_cnt_next;
    logic [7:0]  atk, dec, rel;
    logic [8:0]  atk_sum, sus_inc;

    // Zero rates behave as one so the envelope can never stall mid-phase
    assign atk     = (attack_rate  == 8'd0) ? 8'd1 : attack_rate;
    assign dec     = (decay_rate   == 8'd0) ? 8'd1 : decay_rate;
    assign rel     = (release_rate == 8'd0) ? 8'd1 : release_rate;
    assign atk_sum = {1'b0, env_reg} + {1'b0, atk};
    assign sus_inc = sus_cnt_reg + 9'd1;

    // Envelope state, level and sustain counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            env_reg     <= 8'd0;
            sus_cnt_reg <= 9'd0;
        end else begin
            state_reg   <= state_next;
            env_reg     <= env_next;
            sus_cnt_reg <= sus_cnt_next;
        end
    end

    // Next-state logic: a trigger overrides any tick step that cycle
    always_comb begin
        state_next   = state_reg;
        env_next     = env_reg;
        sus_cnt_next = sus_cnt_reg;
        if (beat_trigger) begin
            state_next   = S_ATTACK;
            sus_cnt_next = 9'd0;
        end else if (tick) begin
            case (state_reg)
                S_ATTACK: begin
                    if (atk_sum[8] || atk_sum[7:0] == 8'hFF) begin
                        env_next   = 8'hFF;
                        state_next = S_DECAY;
                    end else begin
                        env_next = atk_sum[7:0];
                    end
                end
                S_DECAY: begin
                    if ({1'b0, env_reg} > ({1'b0, sustain_level} + {1'b0, dec})) begin
                        env_next = env_reg - dec;
                    end else begin
                        env_next     = sustain_level;
                        state_next   = S_SUSTAIN;
                        sus_cnt_next = 9'd0;
                    end
                end
                S_SUSTAIN: begin
                    env_next     = sustain_level;
                    sus_cnt_next = sus_inc;
                    if (sus_inc >= {1'b0, sustain_ticks}) state_next = S_RELEASE;
                end
                S_RELEASE: begin
                    if (env_reg > rel) begin
                        env_next = env_reg - rel;
                    end else begin
                        env_next   = 8'd0;
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    env_next   = 8'd0;
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign env_level = env_reg;
    assign env_state = state_reg;

    // ---------------- gain ----------------
    logic [BW+16:0] bpm_prod;
    logic [7:0]     bpm_gain;
    logic [15:0]    g_prod;
    logic [BITS-1:0] gs;

    assign bpm_prod = (BW+17)'(bpm_estimate) * (BW+17)'(BPM_K);
    assign bpm_gain = (bpm_prod[BW+16:8] > (BW+9)'(255)) ? 8'hFF : bpm_prod[15:8];
    assign g_prod   = 16'(env_reg) * 16'(bpm_gain);
    assign gs       = BITS'(g_prod[15:8]) << (BITS - 8);

    // ---------------- handshake and centre ----------------
    logic            en, accept;
    logic            valid_out_reg, s1_valid_reg, s1_mode_reg;
    logic [XW-1:0]   cx_reg, cx_use;
    logic [YW-1:0]   cy_reg, cy_use;

    assign en       = !valid_out_reg || out_ready;
    assign in_ready = en;
    assign accept   = valid_in && en;
    // A start-of-frame beat already sees its own new centre
    assign cx_use   = sof ? cx_in : cx_reg;
    assign cy_use   = sof ? cy_in : cy_reg;

    // Latch the pulse centre on each accepted start-of-frame beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx_reg <= XW'(IMAGE_WIDTH / 2);
            cy_reg <= YW'(IMAGE_HEIGHT / 2);
        end else if (accept && sof) begin
            cx_reg <= cx_in;
            cy_reg <= cy_in;
        end
    end

    // ---------------- geometry and output math ----------------
    logic signed [11:0] dy;
    logic signed [23:0] dy2;
    logic [6:0]         r;
    logic [15:0]        r2;

    assign dy  = 12'(pixel_y) - 12'(cy_use);
    assign dy2 = dy * dy;
    assign r   = pulse_amplitude[7:1];
    assign r2  = 16'(r) * 16'(r);

    logic [N_PIX-1:0][BITS-1:0] gain_next, pix_next;
    logic [N_PIX-1:0][BITS-1:0] s1_pix_reg, s1_gain_reg, pix_out_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_PIX; gi++) begin : g_pix
            logic signed [11:0] dx;
            logic signed [23:0] dx2;
            logic [23:0]        d2;
            logic               core, ring;
            logic [BITS:0]      sum;

            assign dx   = 12'(pixel_x[gi]) - 12'(cx_use);
            assign dx2  = dx * dx;
            assign d2   = $unsigned(dx2) + $unsigned(dy2);
            assign core = {d2, 2'b00} < {10'd0, r2};
            assign ring = d2 < {8'd0, r2};
            // Disabled beats carry zero gain so stage 2 passes them through
            assign gain_next[gi] = !filter_enable ? '0 :
                                   core ? gs : ring ? (gs >> 1) : '0;

            assign sum = {1'b0, s1_pix_reg[gi]} + {1'b0, s1_gain_reg[gi]};
            assign pix_next[gi] = (s1_gain_reg[gi] == '0) ? s1_pix_reg[gi] :
                                  s1_mode_reg ? (sum[BITS] ? {BITS{1'b1}} : sum[BITS-1:0]) :
                                  sum[BITS:1];
        end
    endgenerate

    // Stage 1: capture pixels, per-pixel gain and mode; hold when stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= 1'b0;
            s1_pix_reg   <= '0;
            s1_gain_reg  <= '0;
        end else if (en) begin
            s1_valid_reg <= valid_in;
            if (valid_in) begin
                s1_pix_reg  <= pix_in;
                s1_gain_reg <= gain_next;
                s1_mode_reg <= filter_mode;
            end
        end
    end

    // Stage 2: register blended output; hold when stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out_reg <= 1'b0;
            pix_out_reg   <= '0;
        end else if (en) begin
            valid_out_reg <= s1_valid_reg;
            if (s1_valid_reg) pix_out_reg <= pix_next;
        end
    end

    assign valid_out = valid_out_reg;
    assign pix_out   = pix_out_reg;

endmodule

// File: doc/adsr_beat_pulse_filter.md
Name: adsr_beat_pulse_filter

Overview:
Next-generation radial pulse brightness filter for the heart-rate video path. It processes N_PIX pixels per beat under a registered valid/ready pipeline with backpressure. Brightness is driven by a beat-retriggerable ADSR envelope whose rates and levels are programmable at runtime. It adds a programmable pulse centre, two-zone radial falloff and a saturating-add mode, and sits between the pixel stream source and the display/VGA sink.

Parameters:
BITS, 8, pixel width (>=8)
N_PIX, 8, parallel pixels per beat
IMAGE_WIDTH, 640, frame width
IMAGE_HEIGHT, 480, frame height
MAX_BPM, 200, BPM giving full gain
TICK_DIV, 200000, clk cycles per envelope tick (>=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
pix_in  in  BITS x N_PIX  input pixels
pixel_x  in  clog2(IMAGE_WIDTH) x N_PIX  column of each pixel
pixel_y  in  clog2(IMAGE_HEIGHT)  row of the beat
sof  in  1  first beat of frame
valid_in  in  1  input beat valid
in_ready  out  1  filter accepts input
pix_out  out  BITS x N_PIX  output pixels
valid_out  out  1  output beat valid
out_ready  in  1  sink accepts output
cx_in, cy_in  in  clog2(W), clog2(H)  pulse centre, latched on sof
filter_enable  in  1  0 = pass-through
filter_mode  in  1  0 = blend average, 1 = saturating add
beat_trigger  in  1  one-cycle heartbeat strobe
bpm_estimate  in  clog2(MAX_BPM+1)  current BPM
pulse_amplitude  in  8  pulse diameter in pixels
attack_rate, decay_rate, release_rate  in  8 each  envelope step per tick
sustain_level  in  8  sustain envelope value
sustain_ticks  in  8  sustain duration in ticks
env_level  out  8  current envelope
env_state  out  3  current ADSR state

Behaviour:
- Reset (reset=0, async): state IDLE, env_level 0, tick counter 0, pipeline valids 0, pix_out all 0, valid_out 0, latched centre = (IMAGE_WIDTH/2, IMAGE_HEIGHT/2). in_ready=1 after reset.
- Tick: counter 0..TICK_DIV-1. tick=1 for one cycle when counter wraps. Free-running, independent of the pixel stream.
- ADSR encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. A rate of 0 is treated as 1.
- Envelope changes only on a tick, except for beat_trigger:
  - IDLE: env held 0.
  - ATTACK: env=min(255, env+attack_rate). When the new env is 255, go to DECAY.
  - DECAY: env=max(sustain_level, env-decay_rate). When it reaches sustain_level, go to SUSTAIN with sustain counter 0.
  - SUSTAIN: env=sustain_level. Counter increments each tick. When counter==sustain_ticks, go to RELEASE. sustain_ticks=0 leaves SUSTAIN on the first tick.
  - RELEASE: env=max(0, env-release_rate). At 0, go to IDLE.
- beat_trigger in any state: next cycle state=ATTACK, env unchanged (no reset to 0), sustain counter cleared. If trigger and tick coincide, trigger wins and no env step occurs.
- Runtime inputs are sampled live on each tick.
- Gain:
  - bpm_gain = min(255, (bpm_estimate*((256*256)/MAX_BPM))>>8).
  - g = (env_level*bpm_gain)>>8.
  - gs = g<<(BITS-8).
- Geometry, per pixel:
  - dx = x-cx, dy = y-cy (signed, 12 bits). d2 = dx*dx+dy*dy (24 bits).
  - r = pulse_amplitude>>1. r2 = r*r (16 bits).
  - Core zone if 4*d2 < r2: gain = gs.
  - Ring zone if d2 < r2: gain = gs>>1.
  - Otherwise gain = 0. r=0 means no pixel is affected.
- Centre latch: on an accepted beat with sof=1, latch cx_in/cy_in. That beat already uses the new centre.
- Pipeline: two stages, latency 2 accepted beats.
  - Stage 1 registers pixels and per-pixel gain.
  - Stage 2 registers pix_out.
  - Global stall: en = !valid_out | out_ready. in_ready = en (combinational).
  - While en=0, all stages and pix_out hold stable. valid_out is never dropped under backpressure.
- Output per pixel:
  - filter_enable=0 or gain=0: pix_out = pix_in.
  - mode 0: (pix+gain)>>1, computed BITS+1 wide.
  - mode 1: min(2^BITS-1, pix+gain).
  - filter_enable is sampled with the beat in stage 1.
- Reset mid-frame: all in-flight beats are discarded with no output.

Test Plan:
- Reset release, TICK_DIV=4, no trigger -> env_state 0, env_level 0, valid_out 0, in_ready 1.
- attack=64, decay=32, sustain_level=128, sustain_ticks=2, release=64, one trigger -> env per tick 64, 128, 192, 255, 223, 191, 159, 128, 128, 128, 64, 0, then IDLE.
- Trigger during RELEASE at env=64 -> ATTACK resumes from 64 (next tick 128). Trigger coincident with a tick -> no step that tick.
- env=255, bpm=200, amplitude=40, centre (320,240), mode 1, pix 100:
  - pixel (320,240) -> 354 saturates to 255.
  - pixel (335,240) is ring -> 100+127 = 227.
  - pixel (341,240) is outside -> 100.
- Mode 0, same core pixel -> (100+254)>>1 = 177. filter_enable=0 -> 100 at latency 2.
- Continuous valid_in with out_ready low for 5 cycles mid-stream -> in_ready low, pix_out stable, no beat lost or duplicated, order preserved.
